// File: rtl/video_address_sequencer_if.sv
// Display-memory fetch bus between frame timing and the MC6847X address sequencer.
// The master drives timing/mode; the slave returns the fetch address and row state.
interface video_address_sequencer_if #(
  parameter int ADDR_W = 13
);
  logic              preload;
  logic              hsn;
  logic              fsn;
  logic              ag;
  logic [2:0]        gm;
  logic [ADDR_W-1:0] da;
  logic              da0;
  logic [3:0]        cell_row;
  logic              line_full;

  modport master (
    output preload, hsn, fsn, ag, gm,
    input  da, da0, cell_row, line_full
  );

  modport slave (
    input  preload, hsn, fsn, ag, gm,
    output da, da0, cell_row, line_full
  );
endinterface

// File: rtl/video_address_sequencer.sv
// MC6847X display fetch address generator: per-byte advance on preload, per-line
// rewind/advance on hsync falling edge, row repeat set by the mode latched in retrace.
module video_address_sequencer #(
  parameter int ADDR_W = 13
) (
  input  logic                      clk,
  input  logic                      rstn,
  video_address_sequencer_if.slave  bus
);

  logic [ADDR_W-1:0] da_q, da_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] base_next;
  logic [ADDR_W-1:0] start_da;
  logic [5:0]        byte_cnt_q, byte_cnt_d;
  logic [5:0]        cnt_start;
  logic [3:0]        cell_row_q, cell_row_d;
  logic              line_full_q, line_full_d;
  logic              hsn_q;
  logic              ag_q, ag_d;
  logic [2:0]        gm_q, gm_d;

  logic [5:0]        bpr;
  logic [3:0]        div;
  logic              hs_fall;
  logic              boundary;

  // Bytes per source row and row repeat count for the latched mode
  always_comb begin
    bpr = 6'd32;
    div = 4'd12;
    if (ag_q) begin
      case (gm_q)
        3'd0, 3'd1: begin bpr = 6'd16; div = 4'd3; end
        3'd2:       begin bpr = 6'd32; div = 4'd3; end
        3'd3:       begin bpr = 6'd16; div = 4'd2; end
        3'd4:       begin bpr = 6'd32; div = 4'd2; end
        3'd5:       begin bpr = 6'd16; div = 4'd1; end
        default:    begin bpr = 6'd32; div = 4'd1; end
      endcase
    end
  end

  assign hs_fall   = hsn_q & ~bus.hsn;
  assign boundary  = hs_fall && (byte_cnt_q != 6'd0);
  assign base_next = base_q + ADDR_W'(bpr);

  always_comb begin
    da_d        = da_q;
    base_d      = base_q;
    byte_cnt_d  = byte_cnt_q;
    cell_row_d  = cell_row_q;
    line_full_d = line_full_q;
    ag_d        = ag_q;
    gm_d        = gm_q;
    start_da    = da_q;
    cnt_start   = byte_cnt_q;

    if (!bus.fsn) begin
      da_d        = '0;
      base_d      = '0;
      byte_cnt_d  = '0;
      cell_row_d  = '0;
      line_full_d = 1'b0;
      ag_d        = bus.ag;
      gm_d        = bus.gm;
    end else begin
      // Boundary resolves first so a coincident preload lands as byte 0 of the new line
      if (boundary) begin
        if (cell_row_q < div - 4'd1) begin
          cell_row_d = cell_row_q + 4'd1;
          start_da   = base_q;
        end else begin
          cell_row_d = '0;
          base_d     = base_next;
          start_da   = base_next;
        end
        cnt_start   = '0;
        line_full_d = 1'b0;
      end

      da_d       = start_da;
      byte_cnt_d = cnt_start;
      if (bus.preload && (cnt_start < bpr)) begin
        da_d        = start_da + ADDR_W'(1);
        byte_cnt_d  = cnt_start + 6'd1;
        line_full_d = ((cnt_start + 6'd1) == bpr);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      da_q        <= '0;
      base_q      <= '0;
      byte_cnt_q  <= '0;
      cell_row_q  <= '0;
      line_full_q <= 1'b0;
      hsn_q       <= 1'b1;
      ag_q        <= 1'b0;
      gm_q        <= 3'd0;
    end else begin
      da_q        <= da_d;
      base_q      <= base_d;
      byte_cnt_q  <= byte_cnt_d;
      cell_row_q  <= cell_row_d;
      line_full_q <= line_full_d;
      hsn_q       <= bus.hsn;
      ag_q        <= ag_d;
      gm_q        <= gm_d;
    end
  end

  assign bus.da        = da_q;
  assign bus.da0       = da_q[0];
  assign bus.cell_row  = cell_row_q;
  assign bus.line_full = line_full_q;

endmodule

// File: tb/tb_video_address_sequencer.sv
// Scoreboard bench for video_address_sequencer: directed frames per mode, expected
// address/row state queued by the stimulus and checked by an independent monitor.
module tb_video_address_sequencer;

  localparam int ADDR_W = 13;

  logic clk;
  logic rstn;

  video_address_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

  video_address_sequencer #(.ADDR_W(ADDR_W)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  typedef struct {
    string       name;
    int unsigned da;
    int unsigned cell_row;
    bit          line_full;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: outputs are registered, so compare 2 units after each rising edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_vec++;
        if (bus.da !== ADDR_W'(e.da) || bus.da0 !== e.da[0] ||
            bus.cell_row !== 4'(e.cell_row) || bus.line_full !== e.line_full) begin
          n_err++;
          $display("FAIL %s: got da=%0d da0=%0b cell_row=%0d line_full=%0b, want da=%0d da0=%0b cell_row=%0d line_full=%0b",
                   e.name, bus.da, bus.da0, bus.cell_row, bus.line_full,
                   e.da, e.da[0], e.cell_row, e.line_full);
        end
      end
    end
  end

  task automatic expect_st(input string name, input int unsigned da,
                           input int unsigned cr, input bit lf);
    exp_t e;
    e.name = name; e.da = da; e.cell_row = cr; e.line_full = lf;
    exp_q.push_back(e);
  endtask

  task automatic cyc(input bit p, input bit h);
    @(negedge clk);
    bus.preload = p;
    bus.hsn     = h;
  endtask

  task automatic preloads(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b1);
  endtask

  task automatic hedge();
    cyc(1'b0, 1'b0);
  endtask

  task automatic retrace(input bit a, input logic [2:0] g);
    @(negedge clk);
    bus.preload = 1'b0;
    bus.hsn     = 1'b1;
    bus.fsn     = 1'b0;
    bus.ag      = a;
    bus.gm      = g;
    @(negedge clk);
    bus.fsn = 1'b1;
  endtask

  initial begin
    rstn        = 1'b0;
    bus.preload = 1'b0;
    bus.hsn     = 1'b1;
    bus.fsn     = 1'b0;
    bus.ag      = 1'b1;
    bus.gm      = 3'd6;
    expect_st("reset", 0, 0, 1'b0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus.fsn = 1'b1;

    // gm6: 32 bytes, no row repeat
    preloads(31);            expect_st("gm6_31b", 31, 0, 1'b0);
    preloads(1);             expect_st("gm6_full", 32, 0, 1'b1);
    hedge();                 expect_st("gm6_edge1", 32, 0, 1'b0);
    preloads(32);            expect_st("gm6_line2", 64, 0, 1'b1);
    hedge();                 expect_st("gm6_edge2", 64, 0, 1'b0);

    // gm3: 16 bytes, x2
    retrace(1'b1, 3'd3);     expect_st("retrace_clr", 0, 0, 1'b0);
    preloads(16);            expect_st("gm3_full", 16, 0, 1'b1);
    hedge();                 expect_st("gm3_rewind", 0, 1, 1'b0);
    preloads(16);            expect_st("gm3_rep", 16, 1, 1'b1);
    hedge();                 expect_st("gm3_adv", 16, 0, 1'b0);

    // Alpha: 32 bytes, x12
    retrace(1'b0, 3'd0);
    for (int r = 0; r < 12; r++) begin
      preloads(32);          expect_st($sformatf("alpha_row%0d", r), 32, r, 1'b1);
      hedge();
      if (r < 11)            expect_st($sformatf("alpha_rew%0d", r), 0, r + 1, 1'b0);
      else                   expect_st("alpha_adv", 32, 0, 1'b0);
    end

    // gm6 overrun and blank line
    retrace(1'b1, 3'd6);
    preloads(40);            expect_st("gm6_overrun", 32, 0, 1'b1);
    hedge();                 expect_st("gm6_ovr_edge", 32, 0, 1'b0);
    cyc(1'b0, 1'b1);
    hedge();                 expect_st("blank_line", 32, 0, 1'b0);

    // Coincident boundary and preload
    retrace(1'b1, 3'd6);
    preloads(32);            expect_st("simul_pre", 32, 0, 1'b1);
    cyc(1'b1, 1'b0);         expect_st("simul", 33, 0, 1'b0);
    cyc(1'b1, 1'b1);
    preloads(30);            expect_st("simul_fill", 64, 0, 1'b1);

    // Mode change during active display is not applied
    retrace(1'b1, 3'd6);
    @(negedge clk);
    bus.gm = 3'd0;
    preloads(32);            expect_st("frozen_bpr", 32, 0, 1'b1);
    hedge();                 expect_st("frozen_div", 32, 0, 1'b0);
    preloads(5);             expect_st("frozen_mid", 37, 0, 1'b0);

    // Retrace mid-frame picks up gm0
    retrace(1'b1, 3'd0);     expect_st("gm0_retrace", 0, 0, 1'b0);
    preloads(20);            expect_st("gm0_cap", 16, 0, 1'b1);
    hedge();                 expect_st("gm0_rew1", 0, 1, 1'b0);
    preloads(16);
    hedge();                 expect_st("gm0_rew2", 0, 2, 1'b0);
    preloads(16);
    hedge();                 expect_st("gm0_adv", 16, 0, 1'b0);

    // Async reset mid-line, released before the next rising edge
    retrace(1'b1, 3'd6);
    preloads(20);            expect_st("pre_reset", 20, 0, 1'b0);
    @(negedge clk);
    bus.preload = 1'b0;
    #1 rstn = 1'b0;
    #2 rstn = 1'b1;
    expect_st("async_reset", 0, 0, 1'b0);
    preloads(5);             expect_st("post_reset", 5, 0, 1'b0);
    cyc(1'b0, 1'b1);

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/video_address_sequencer.md
Name: video_address_sequencer

Overview:
- Generates the display-memory fetch address (DA12..DA0) for the MC6847X.
- Advances one byte per preload pulse from frame timing and rewinds or advances the line base at each horizontal sync.
- Repeats source rows per the active AG/GM mode: x1, x2, x3 or x12 (alpha/semigraphics).
- Replaces the tied-off DA0 at top level and supplies the character-cell row counter.

Parameters:
- ADDR_W, 13, width of the fetch address (DA12..DA0).

Ports:
- clk  input  1  video clock (same clock as frame timing)
- rstn  input  1  asynchronous active-low reset
- preload  input  1  one-cycle pulse; the byte at da has been fetched
- hsn  input  1  horizontal sync, active low; falling edge = line boundary
- fsn  input  1  field sync, active low; low = vertical retrace
- ag  input  1  0 = alpha/semigraphics, 1 = graphics
- gm  input  3  graphics mode 0..7
- da  output  ADDR_W  current fetch address
- da0  output  1  da[0]
- cell_row  output  4  row repeat index within the current source row (0..div-1)
- line_full  output  1  all bytes of the current line have been fetched

Behaviour:
- Reset (rstn low, async): da=0, line base=0, byte_cnt=0, cell_row=0, line_full=0, hsn_d=1, latched mode = alpha (ag=0, gm=0).
- Mode table, latched from ag/gm (bytes per row bpr, row divisor div):
  - ag=0: 32, 12
  - gm0: 16, 3
  - gm1: 16, 3
  - gm2: 32, 3
  - gm3: 16, 2
  - gm4: 32, 2
  - gm5: 16, 1
  - gm6: 32, 1
  - gm7: 32, 1
- Mode latch: ag/gm are sampled every clk while fsn=0 and frozen while fsn=1. Changes during active display take effect at the next retrace.
- Retrace (fsn=0): da, base, byte_cnt, cell_row and line_full are cleared synchronously. Preload and hsn edges are ignored.
- hsn falling edge is detected as hsn_d & ~hsn, with hsn_d registered every clk.
- Preload with fsn=1 and byte_cnt<bpr: da<=da+1, byte_cnt<=byte_cnt+1. line_full<=1 when byte_cnt+1==bpr.
- Preload with byte_cnt==bpr: ignored; da holds.
- Line boundary (hsn falling edge, fsn=1, byte_cnt!=0):
  - If cell_row<div-1: cell_row++, da<=base (rewind).
  - Else: cell_row<=0, base<=base+bpr, da<=base+bpr.
  - In both cases byte_cnt<=0 and line_full<=0.
- Line boundary with byte_cnt==0 (blank/border line): no change to any state.
- Simultaneous hsn falling edge and preload: the boundary is applied first, then the preload counts as byte 0 of the new line. Result: da = new line start + 1, byte_cnt = 1.
- Arithmetic is modulo 2^ADDR_W; base and da wrap 8191 -> 0 silently. A normal frame peaks at 6144.
- All state updates complete in one clk. da is valid the cycle after the preload or edge that changed it.
- Reset asserted mid-line returns all state to reset values immediately. The first line after release begins from da=0.

Test Plan:
- Reset, fsn=0 with ag=1 gm=6, then fsn=1; 32 preloads -> da=32, line_full=1; hsn falling edge -> da=32, line_full=0, cell_row=0; 32 more preloads then edge -> da=64.
- gm=3 latched; 16 preloads -> da=16; edge -> da=0, cell_row=1; 16 preloads, edge -> da=16, cell_row=0.
- ag=0 latched; 12 lines of 32 preloads -> da returns to 0 after each of the first 11 edges, cell_row steps 0..11 then 0; after the 12th edge da=32.
- gm=6; 40 preloads in one line -> da stops at 32; extra pulses ignored; a hsn edge with no prior preloads changes nothing.
- Preload and hsn falling edge in the same clk at byte_cnt=32 (gm6, base 0) -> da=33, byte_cnt=1.
- Change gm 6->0 while fsn=1 -> row stepping stays x1/32B.
- Drive fsn=0 mid-frame -> da=0, cell_row=0, and gm0 takes effect (16B, x3).
- Pulse rstn low mid-line at da=20 -> da=0 asynchronously, before the next clk.
